// File: rtl/affine_ref_feeder.sv
`default_nettype none
// ============================================================================
// Module      : affine_ref_feeder
// Description : Streams reference rows from a synchronous RAM. Rows are
//               grouped in fours and each group is handed to the consumer
//               through a valid/ready handshake. The word count is rounded
//               down to a multiple of 4 and saturated to the RAM depth.
// Revision    : 1.0  initial release
// ============================================================================
module affine_ref_feeder #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [ADDR_W:0]   num_words,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] ref_line_0,
    output logic [DATA_W-1:0] ref_line_1,
    output logic [DATA_W-1:0] ref_line_2,
    output logic [DATA_W-1:0] ref_line_3,
    output logic              line_valid,
    input  logic              line_ready,
    output logic              busy,
    output logic              load_done
);

    localparam int                GRP_W          = ADDR_W - 2;
    localparam logic [ADDR_W:0]   c_MAX_WORDS    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-2:0] c_MAX_GROUPS   = {1'b1, {GRP_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-2:0]   r_num_groups;
    logic [GRP_W-1:0]    r_group;
    logic [1:0]          r_off;
    logic                r_rd_d;
    logic [1:0]          r_slot_d;
    logic [ADDR_W-2:0]   w_num_groups;
    logic [ADDR_W-2:0]   w_group_inc;
    logic                w_last;
    logic                w_handshake;

    // Group count: saturate to the RAM depth, then drop the partial group.
    assign w_num_groups = (num_words > c_MAX_WORDS) ? c_MAX_GROUPS : num_words[ADDR_W:2];
    assign w_group_inc  = {1'b0, r_group} + (ADDR_W-1)'(1);
    assign w_last       = (w_group_inc == r_num_groups);
    assign w_handshake  = (r_state == S_HOLD) && line_ready;

    // Address is the group index with the row offset; it is held outside FETCH.
    assign mem_addr   = {r_group, r_off};
    assign mem_rd_en  = (r_state == S_FETCH);
    assign line_valid = (r_state == S_HOLD);
    assign busy       = (r_state != S_IDLE);
    assign load_done  = (r_state == S_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (load_req) w_next = (w_num_groups == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (r_off == 2'd3) w_next = S_WAIT;
            S_WAIT:  w_next = S_HOLD;
            S_HOLD:  if (line_ready) w_next = w_last ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Count latch plus group/offset counters; offset parks at 3 after a fetch
    // burst so the last issued address stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_groups <= '0;
            r_group      <= '0;
            r_off        <= '0;
        end else begin
            if ((r_state == S_IDLE) && load_req) begin
                r_num_groups <= w_num_groups;
                r_group      <= '0;
                r_off        <= '0;
            end else if ((r_state == S_FETCH) && (r_off != 2'd3)) begin
                r_off <= r_off + 2'd1;
            end else if (w_handshake && !w_last) begin
                r_group <= w_group_inc[GRP_W-1:0];
                r_off   <= '0;
            end
        end
    end

    // Capture each RAM word one cycle after its read into the matching slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_d     <= 1'b0;
            r_slot_d   <= '0;
            ref_line_0 <= '0;
            ref_line_1 <= '0;
            ref_line_2 <= '0;
            ref_line_3 <= '0;
        end else begin
            r_rd_d   <= mem_rd_en;
            r_slot_d <= r_off;
            if (r_rd_d) begin
                case (r_slot_d)
                    2'd0:    ref_line_0 <= mem_rd_data;
                    2'd1:    ref_line_1 <= mem_rd_data;
                    2'd2:    ref_line_2 <= mem_rd_data;
                    default: ref_line_3 <= mem_rd_data;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_affine_ref_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_affine_ref_feeder
// Description : Randomized self-checking bench for affine_ref_feeder with a
//               RAM model and a group-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_affine_ref_feeder;

    localparam int DW = 128;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_req = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] ref_line_0, ref_line_1, ref_line_2, ref_line_3;
    logic          line_valid;
    logic          line_ready = 1'b0;
    logic          busy;
    logic          load_done;

    logic [DW-1:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    affine_ref_feeder #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .num_words(num_words),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .ref_line_0(ref_line_0), .ref_line_1(ref_line_1),
        .ref_line_2(ref_line_2), .ref_line_3(ref_line_3),
        .line_valid(line_valid), .line_ready(line_ready),
        .busy(busy), .load_done(load_done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, DW'(mem_rd_en), '0);
        check({tag, "_addr"},  DW'(mem_addr), '0);
        check({tag, "_lines"}, ref_line_0 | ref_line_1 | ref_line_2 | ref_line_3, '0);
        check({tag, "_valid"}, DW'(line_valid), '0);
        check({tag, "_busy"},  DW'(busy), '0);
        check({tag, "_done"},  DW'(load_done), '0);
    endtask

    // One load sequence. Called at a falling edge; mode 0 = ready held high,
    // 1 = random ready, 2 = ready low for 10 cycles of every HOLD.
    task automatic run_load(input int num, input int mode, input bit busy_pulse);
        int  n_exp, groups, grp, exp_addr, rd_count, last_hs, done_cyc, done_cnt, stall, bound;
        bit  fin;
        n_exp    = ((num > 4096) ? 4096 : num) / 4 * 4;
        groups   = n_exp / 4;
        grp      = 0;
        exp_addr = 0;
        rd_count = 0;
        last_hs  = 0;
        done_cyc = 0;
        done_cnt = 0;
        stall    = 0;
        fin      = 1'b0;
        bound    = 20 * groups + 40;
        load_req  = 1'b1;
        num_words = (AW+1)'(num);
        for (int cyc = 1; cyc <= bound && !fin; cyc++) begin
            @(negedge clk);
            load_req = busy_pulse && (cyc == 3);
            if (busy_pulse && cyc == 3) num_words = 13'd12;
            case (mode)
                0:       line_ready = 1'b1;
                1:       line_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (line_valid) begin
                        line_ready = (stall >= 10);
                        stall++;
                    end else begin
                        line_ready = 1'($urandom_range(0, 1));
                    end
                end
            endcase
            if (cyc == 1) check("busy_start", DW'(busy), DW'(1));
            if (mem_rd_en) begin
                check("rd_addr", DW'(mem_addr), DW'(exp_addr));
                exp_addr++;
                rd_count++;
            end
            if (line_valid) begin
                if (grp < groups) begin
                    check("line0", ref_line_0, mem[4*grp]);
                    check("line1", ref_line_1, mem[4*grp+1]);
                    check("line2", ref_line_2, mem[4*grp+2]);
                    check("line3", ref_line_3, mem[4*grp+3]);
                end else begin
                    check("extra_group", DW'(grp), DW'(groups));
                end
                check("reads", DW'(rd_count), DW'(4*(grp+1)));
                if (mode == 0) check("valid_cyc", DW'(cyc), DW'(6 + 6*grp));
                if (line_ready) begin
                    grp++;
                    last_hs = cyc;
                    stall   = 0;
                end
            end
            if (load_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    check("groups", DW'(grp), DW'(groups));
                    check("done_cyc", DW'(cyc), DW'(last_hs + 1));
                    done_cyc = cyc;
                end else begin
                    check("single_done", DW'(done_cnt), DW'(1));
                end
            end
            if (done_cnt > 0 && cyc == done_cyc + 4) begin
                check("idle_busy", DW'(busy), '0);
                check("total_reads", DW'(rd_count), DW'(n_exp));
                if (groups > 0) check("final_addr", DW'(mem_addr), DW'(n_exp - 1));
                fin = 1'b1;
            end
        end
        if (!fin) check("timeout", '0, DW'(1));
        load_req   = 1'b0;
        line_ready = 1'b0;
    endtask

    // Reset asserted while a group is held, then a fresh load right after release.
    task automatic reset_mid_hold();
        bit seen;
        seen       = 1'b0;
        load_req   = 1'b1;
        num_words  = 13'd8;
        line_ready = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            load_req = 1'b0;
            seen     = line_valid;
        end
        check("hold_reached", DW'(seen), DW'(1));
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", DW'(load_done), '0);
        end
        rst_n = 1'b1;
        run_load(8, 0, 1'b0);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_load(8, 0, 1'b0);
        run_load(4, 2, 1'b0);
        run_load(6, 0, 1'b0);
        run_load(3, 0, 1'b0);
        run_load(0, 0, 1'b0);
        run_load(4096, 0, 1'b0);
        run_load(6000, 1, 1'b0);
        run_load(20, 0, 1'b1);
        reset_mid_hold();
        for (int t = 0; t < 4; t++) run_load($urandom_range(0, 200), $urandom_range(0, 2), 1'b0);
        run_load(40, 2, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
